// File: rtl/spi_readout_slave_if.sv
// SPI pin bundle between the Zynq (master) and the readout slave.
interface spi_readout_slave_if;
    logic spi_sclk;
    logic spi_ss_n;
    logic spi_mosi;
    logic spi_miso;

    modport master (
        output spi_sclk,
        output spi_ss_n,
        output spi_mosi,
        input  spi_miso
    );

    modport slave (
        input  spi_sclk,
        input  spi_ss_n,
        input  spi_mosi,
        output spi_miso
    );
endinterface

// File: rtl/spi_readout_slave.sv
// SPI mode-0 slave streaming channel-buffer words to the Zynq while capturing a
// command word; owns the buffer read address and wraps it at the programmed count.
module spi_readout_slave #(
    parameter int unsigned WORD_BITS   = 16,
    parameter int unsigned ADDR_BITS   = 12,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RD_LATENCY  = 1
) (
    input  logic                 sysclk,
    input  logic                 rst,
    spi_readout_slave_if.slave   spi,
    input  logic [15:0]          zynq_word_num,
    input  logic [WORD_BITS-1:0] rd_data,
    output logic [ADDR_BITS-1:0] rd_addr,
    output logic                 spi_done,
    output logic [WORD_BITS-1:0] cmd_word,
    output logic                 cmd_valid,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(WORD_BITS);
    localparam int unsigned LAT_W = $clog2(RD_LATENCY + 2);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        SHIFT,
        LOAD
    } state_e;

    // Pin synchronizers, packed as {sclk, ss_n, mosi}
    logic [2:0] sync_q [SYNC_STAGES];
    logic       sclk_s;
    logic       ss_n_s;
    logic       mosi_s;
    logic       sclk_d1_q;
    logic       ss_n_d1_q;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       ss_fall;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= 3'b010;
            end
            sclk_d1_q <= 1'b0;
            ss_n_d1_q <= 1'b1;
        end else begin
            sync_q[0] <= {spi.spi_sclk, spi.spi_ss_n, spi.spi_mosi};
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            sclk_d1_q <= sclk_s;
            ss_n_d1_q <= ss_n_s;
        end
    end

    assign {sclk_s, ss_n_s, mosi_s} = sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d1_q;
    assign sclk_fall = ~sclk_s & sclk_d1_q;
    assign ss_fall   = ~ss_n_s & ss_n_d1_q;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [LAT_W-1:0]     lat_q, lat_d;
    logic [WORD_BITS-1:0] shift_in_q, shift_in_d;
    logic [WORD_BITS-1:0] shift_out_q, shift_out_d;
    logic                 skip_q, skip_d;
    logic                 fall_pend_q, fall_pend_d;
    logic                 miso_q, miso_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic                 done_q, done_d;
    logic                 cmd_valid_q, cmd_valid_d;
    logic [WORD_BITS-1:0] cmd_word_q, cmd_word_d;
    logic                 busy_q, busy_d;
    logic [15:0]          addr_ext;
    logic [ADDR_BITS-1:0] addr_next;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            lat_q       <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            skip_q      <= 1'b0;
            fall_pend_q <= 1'b0;
            miso_q      <= 1'b0;
            rd_addr_q   <= '0;
            done_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_word_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            lat_q       <= lat_d;
            shift_in_q  <= shift_in_d;
            shift_out_q <= shift_out_d;
            skip_q      <= skip_d;
            fall_pend_q <= fall_pend_d;
            miso_q      <= miso_d;
            rd_addr_q   <= rd_addr_d;
            done_q      <= done_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_word_q  <= cmd_word_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        lat_d       = lat_q;
        shift_in_d  = shift_in_q;
        shift_out_d = shift_out_q;
        skip_d      = skip_q;
        fall_pend_d = fall_pend_q;
        miso_d      = miso_q;
        rd_addr_d   = rd_addr_q;
        done_d      = 1'b0;
        cmd_valid_d = 1'b0;
        cmd_word_d  = cmd_word_q;
        busy_d      = ~ss_n_s;

        // Counts of 0 or 1 keep the address pinned at zero
        addr_ext  = 16'(rd_addr_q);
        addr_next = (zynq_word_num > 16'd1 && addr_ext < zynq_word_num - 16'd1)
                    ? rd_addr_q + ADDR_BITS'(1) : '0;

        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                lat_d     = '0;
                miso_d    = 1'b0;
                rd_addr_d = '0;
                if (ss_fall) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                if (lat_q == LAT_W'(RD_LATENCY - 1)) begin
                    shift_out_d = rd_data;
                    miso_d      = rd_data[WORD_BITS-1];
                    bit_cnt_d   = '0;
                    skip_d      = 1'b0;
                    fall_pend_d = 1'b0;
                    state_d     = SHIFT;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    shift_in_d = {shift_in_q[WORD_BITS-2:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(WORD_BITS - 1)) begin
                        done_d      = 1'b1;
                        cmd_valid_d = 1'b1;
                        cmd_word_d  = {shift_in_q[WORD_BITS-2:0], mosi_s};
                        lat_d       = '0;
                        fall_pend_d = 1'b0;
                        state_d     = LOAD;
                    end
                end else if (sclk_fall) begin
                    // First fall after a reload only exposes the new MSB
                    if (skip_q) begin
                        skip_d = 1'b0;
                        miso_d = shift_out_q[WORD_BITS-1];
                    end else begin
                        shift_out_d = shift_out_q << 1;
                        miso_d      = shift_out_q[WORD_BITS-2];
                    end
                end
            end
            LOAD: begin
                if (lat_q == '0) begin
                    rd_addr_d = addr_next;
                end
                if (sclk_fall) begin
                    fall_pend_d = 1'b1;
                end
                // rd_data reflects the new address RD_LATENCY cycles after it settles
                if (lat_q == LAT_W'(RD_LATENCY + 1)) begin
                    shift_out_d = rd_data;
                    state_d     = SHIFT;
                    fall_pend_d = 1'b0;
                    if (sclk_fall || fall_pend_q) begin
                        miso_d = rd_data[WORD_BITS-1];
                        skip_d = 1'b0;
                    end else begin
                        skip_d = 1'b1;
                    end
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // SS release aborts any partial word; a word completing this cycle still reports
        if (state_q != IDLE && ss_n_s) begin
            state_d     = IDLE;
            bit_cnt_d   = '0;
            lat_d       = '0;
            miso_d      = 1'b0;
            rd_addr_d   = '0;
            skip_d      = 1'b0;
            fall_pend_d = 1'b0;
        end
    end

    assign spi.spi_miso = miso_q;
    assign rd_addr      = rd_addr_q;
    assign spi_done     = done_q;
    assign cmd_valid    = cmd_valid_q;
    assign cmd_word     = cmd_word_q;
    assign busy         = busy_q;

endmodule

// File: doc/spi_readout_slave.md
# spi_readout_slave

SPI slave that streams buffered ADC samples from the digitizer channel buffer to the Zynq. It sits directly downstream of the single-channel buffer and owns the buffer read address. Each 16-bit word is shifted out MSB-first on MISO while a 16-bit command word is captured from MOSI. Every completed transfer produces a one-cycle done pulse and advances the read address, wrapping after the Zynq-programmed word count.

## Interface
Parameters:
- WORD_BITS, 16, bits per SPI word (fixed 16 in this design)
- ADDR_BITS, 12, width of read address
- SYNC_STAGES, 2, flip-flops in each SCLK/SS/MOSI synchronizer
- RD_LATENCY, 1, sysclk cycles from rd_addr change to valid rd_data (legal 1..2)

Ports:
- sysclk  in  1  system clock; only clock in the block
- rst  in  1  synchronous, active-high reset
- spi_sclk  in  1  SPI clock from Zynq, asynchronous, mode 0 (CPOL=0, CPHA=0)
- spi_ss_n  in  1  slave select, active low, asynchronous
- spi_mosi  in  1  serial data from Zynq, asynchronous
- spi_miso  out  1  serial data to Zynq, registered
- zynq_word_num  in  16  words per readout; address wraps after zynq_word_num-1
- rd_data  in  16  buffer word at rd_addr
- rd_addr  out  ADDR_BITS  buffer read address
- spi_done  out  1  one-cycle pulse per completed 16-bit transfer
- cmd_word  out  16  last complete word received on MOSI
- cmd_valid  out  1  one-cycle pulse, coincident with spi_done, cmd_word updated
- busy  out  1  high while SS is synchronously asserted

## Operation
- SCLK, SS_n and MOSI each pass through SYNC_STAGES flip-flops, then a one-flop edge detector; all logic uses the synchronized versions.
- FSM states:
  - IDLE: SS deasserted; bit counter 0; spi_miso 0; rd_addr 0.
  - ARM: entered on SS falling edge; wait RD_LATENCY cycles; load shift_out from rd_data; spi_miso = shift_out[15].
  - SHIFT: on each synchronized SCLK rising edge, shift spi_mosi into shift_in LSB and increment the 4-bit bit counter. On each falling edge, shift shift_out left and drive the new MSB.
  - LOAD: entered after the 16th rising edge; pulse spi_done and cmd_valid; cmd_word <= shift_in; advance rd_addr; wait RD_LATENCY cycles, reload shift_out from rd_data; return to SHIFT.
  - At the next falling edge, spi_miso presents the new word's MSB; that falling edge does not shift.
- Address rule:
  - If rd_addr < zynq_word_num-1, rd_addr+1; else 0.
  - zynq_word_num = 0 or 1: rd_addr holds 0.
  - Comparison uses a 16-bit zero-extended rd_addr.
- SS deassert in any state: go to IDLE next cycle; discard the partial word; no spi_done; rd_addr <= 0.
- SS deassert in the same cycle as the 16th rising edge: the word completes (spi_done fires), then IDLE.
- rst overrides everything.
- Reset values: spi_miso 0, rd_addr 0, spi_done 0, cmd_valid 0, cmd_word 0, busy 0; FSM in IDLE.

## Timing
- SCLK frequency must be at most sysclk/8; SS setup to first SCLK rising edge must be at least 6 sysclk cycles.
- Input-to-action latency: SYNC_STAGES+1 sysclk cycles from a pin edge to the FSM acting on it.
- spi_done/cmd_valid assert SYNC_STAGES+1 cycles after the 16th SCLK rising edge at the pin, high exactly 1 cycle.
- rd_addr updates the cycle after spi_done. Reload of shift_out happens RD_LATENCY cycles later, always before the next SCLK falling edge.
- spi_miso changes no earlier than SYNC_STAGES+1 cycles after a falling SCLK edge, and never near a rising edge.
- busy tracks synchronized SS with SYNC_STAGES+1 cycles latency.

## Test plan
- Reset check: assert rst 3 cycles mid-transfer -> all outputs 0, FSM IDLE; the next transfer starts at rd_addr 0.
- Single word: buffer[0]=0xA5C3, MOSI sends 0x1234, SCLK=sysclk/8 -> MISO bits 0xA5C3 MSB-first; one spi_done; cmd_word=0x1234; rd_addr=1.
- Burst with wrap: zynq_word_num=3, buffer = 0x0001, 0x0002, 0x0003; 5 words under one SS -> MISO 1,2,3,1,2; rd_addr 1,2,0,1,2; 5 spi_done pulses.
- Abort: SS deasserted after 9 bits -> no spi_done, rd_addr 0, busy falls SYNC_STAGES+1 cycles later; the next SS starts at buffer[0].
- zynq_word_num=0: 4 words -> all read from address 0, rd_addr stays 0, 4 spi_done pulses.
- Fastest legal SCLK (sysclk/8), RD_LATENCY=2: 64 words back-to-back -> no bit errors; each MSB valid before its rising edge.
